// File: rtl/perceptron_pkg.sv
// Shared types and width helpers for the sequential binary perceptron layer.
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int N_IN_DEF   = 8;
    localparam int N_OUT_DEF  = 8;
    localparam int W_W_DEF    = 8;
    localparam int THRESH_DEF = 2;
    localparam int DEF_W_DEF  = 1;
    localparam int DEF_B_DEF  = 0;

    localparam int IDX_W_DEF  = $clog2(N_IN_DEF + 1);
    localparam int NRN_W_DEF  = (N_OUT_DEF > 1) ? $clog2(N_OUT_DEF) : 1;

    // Worst case sum is (N_IN+1) * (2^W_W - 1), which always fits in this width.
    function automatic int acc_width(input int w_w, input int n_in);
        return w_w + $clog2(n_in + 2);
    endfunction

    function automatic int idx_width(input int n_in);
        return $clog2(n_in + 1);
    endfunction

    function automatic int nrn_width(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

    function automatic int cnt_width(input int n_in);
        return (n_in > 1) ? $clog2(n_in) : 1;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// One neuron: weight/bias storage plus a serial multiply-accumulate over binary inputs.
// Storage is writable only when WEIGHT_LOAD_EN is defined; otherwise it is the DEF_W/DEF_B constants.
module neuron_mac
    import perceptron_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int W_W    = W_W_DEF,
    parameter int ACC_W  = acc_width(W_W_DEF, N_IN_DEF),
    parameter int CNT_W  = cnt_width(N_IN_DEF),
    parameter int IDX_W  = IDX_W_DEF,
    parameter int THRESH = THRESH_DEF,
    parameter int DEF_W  = DEF_W_DEF,
    parameter int DEF_B  = DEF_B_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_last,
    input  logic             i_x_bit,
    input  logic [CNT_W-1:0] i_idx,
    input  logic             i_cfg_we,
    input  logic [IDX_W-1:0] i_cfg_idx,
    input  logic [W_W-1:0]   i_cfg_data,
    output logic             o_y
);

    logic [W_W-1:0]   w_wt [N_IN];
    logic [W_W-1:0]   w_bias_load;
    logic [W_W-1:0]   w_wsel;
    logic [W_W-1:0]   w_addend;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_y;

`ifdef WEIGHT_LOAD_EN
    logic [W_W-1:0] r_wt [N_IN];
    logic [W_W-1:0] r_bias;
    logic           w_bias_we;

    assign w_bias_we = i_cfg_we && (i_cfg_idx == IDX_W'(N_IN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                r_wt[i] <= W_W'(DEF_W);
            end
            r_bias <= W_W'(DEF_B);
        end else if (i_cfg_we) begin
            for (int i = 0; i < N_IN; i++) begin
                if (i_cfg_idx == IDX_W'(i)) begin
                    r_wt[i] <= i_cfg_data;
                end
            end
            if (w_bias_we) begin
                r_bias <= i_cfg_data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_wt[i] = r_wt[i];
        end
    end

    // A bias write in the accept cycle must reach the accumulator preload.
    assign w_bias_load = w_bias_we ? i_cfg_data : r_bias;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{i_cfg_we, i_cfg_idx, i_cfg_data};

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_wt[i] = W_W'(DEF_W);
        end
    end

    assign w_bias_load = W_W'(DEF_B);
`endif

    always_comb begin
        w_wsel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (i_idx == CNT_W'(i)) begin
                w_wsel = w_wt[i];
            end
        end
    end

    assign w_addend  = i_x_bit ? w_wsel : '0;
    assign w_acc_nxt = r_acc + ACC_W'(w_addend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_y   <= 1'b0;
        end else if (i_load) begin
            r_acc <= ACC_W'(w_bias_load);
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
            if (i_last) begin
                r_y <= (w_acc_nxt >= ACC_W'(THRESH));
            end
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/perceptron_layer_seq.sv
// Single-layer binary perceptron: N_OUT neurons in parallel, inputs walked one bit per cycle.
// Runtime weight/bias loading through the cfg port exists only when WEIGHT_LOAD_EN is defined.
//
//   state   | meaning
//   IDLE    | waiting for an input vector; cfg writes accepted
//   COMPUTE | one MAC per neuron per cycle, N_IN cycles
//   DONE    | out_y valid, held until out_ready
module perceptron_layer_seq
    import perceptron_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int W_W    = W_W_DEF,
    parameter int THRESH = THRESH_DEF,
    parameter int DEF_W  = DEF_W_DEF,
    parameter int DEF_B  = DEF_B_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN-1:0]             in_x,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_OUT-1:0]            out_y,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [nrn_width(N_OUT)-1:0] cfg_neuron,
    input  logic [idx_width(N_IN)-1:0]  cfg_index,
    input  logic [W_W-1:0]              cfg_data
);

    localparam int IDX_W = idx_width(N_IN);
    localparam int NRN_W = nrn_width(N_OUT);
    localparam int CNT_W = cnt_width(N_IN);
    localparam int ACC_W = acc_width(W_W, N_IN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [N_IN-1:0]  r_x;
    logic             r_live;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_x_bit;
    logic             w_cfg_fire;
    logic [N_OUT-1:0] w_y;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = r_live;
                if (in_valid && r_live) begin
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(N_IN - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign w_last   = w_step && (r_cnt == CNT_W'(N_IN - 1));
    assign w_x_bit  = r_x[r_cnt];

    // r_live keeps the ready outputs low for the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_x   <= in_x;
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef WEIGHT_LOAD_EN
    assign cfg_ready  = (r_state == IDLE) && r_live;
    assign w_cfg_fire = cfg_valid && cfg_ready;
`else
    logic w_unused_cfg_valid;

    assign w_unused_cfg_valid = cfg_valid;
    assign cfg_ready          = 1'b0;
    assign w_cfg_fire         = 1'b0;
`endif

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        neuron_mac #(
            .N_IN   (N_IN),
            .W_W    (W_W),
            .ACC_W  (ACC_W),
            .CNT_W  (CNT_W),
            .IDX_W  (IDX_W),
            .THRESH (THRESH),
            .DEF_W  (DEF_W),
            .DEF_B  (DEF_B)
        ) u_mac (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_accept),
            .i_step     (w_step),
            .i_last     (w_last),
            .i_x_bit    (w_x_bit),
            .i_idx      (r_cnt),
            .i_cfg_we   (w_cfg_fire && (cfg_neuron == NRN_W'(j))),
            .i_cfg_idx  (cfg_index),
            .i_cfg_data (cfg_data),
            .o_y        (w_y[j])
        );
    end

    assign out_y = w_y;

endmodule

// File: tb/tb_perceptron_layer_seq.sv
// Directed, table-driven bench for perceptron_layer_seq at default parameters.
// Covers both builds: cfg-port sequences run only when WEIGHT_LOAD_EN is defined.
module tb_perceptron_layer_seq;

`ifdef WEIGHT_LOAD_EN
    localparam logic CFG_EN = 1'b1;
`else
    localparam logic CFG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_y;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_neuron = '0;
    logic [3:0] cfg_index = '0;
    logic [7:0] cfg_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
    } vec_t;

    vec_t tbl [8];

    perceptron_layer_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_neuron (cfg_neuron),
        .cfg_index  (cfg_index),
        .cfg_data   (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [7:0] x);
        int guard;
        @(negedge clk);
        in_x     = x;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat counts edges from the accept edge (1) to the one after which out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [7:0] x, input logic [7:0] exp_y);
        int lat;
        accept(x);
        wait_done(lat);
        check({name, " latency"}, lat, 9);
        check({name, " out_y"}, out_y, exp_y);
        handshake();
        check({name, " in_ready after handshake"}, in_ready, 1);
    endtask

    task automatic cfg_write(input logic [2:0] n, input logic [3:0] idx, input logic [7:0] d);
        @(negedge clk);
        cfg_neuron = n;
        cfg_index  = idx;
        cfg_data   = d;
        cfg_valid  = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        tbl[0] = '{x: 8'h03, y: 8'hFF};
        tbl[1] = '{x: 8'h01, y: 8'h00};
        tbl[2] = '{x: 8'h00, y: 8'h00};
        tbl[3] = '{x: 8'h80, y: 8'h00};
        tbl[4] = '{x: 8'hC0, y: 8'hFF};
        tbl[5] = '{x: 8'h81, y: 8'hFF};
        tbl[6] = '{x: 8'h10, y: 8'h00};
        tbl[7] = '{x: 8'hFF, y: 8'hFF};

        // reset state
        #2;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_y", out_y, 0);
        check("reset cfg_ready", cfg_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", in_ready, 1);
        check("post-reset cfg_ready", cfg_ready, CFG_EN);

        // default weights 1, bias 0, threshold 2
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("default vec %0d", i), tbl[i].x, tbl[i].y);
        end

`ifdef WEIGHT_LOAD_EN
        // bias of neuron 3 = 5
        cfg_write(3'd3, 4'd8, 8'd5);
        run_vec("bias3=5 x=00", 8'h00, 8'h08);
        run_vec("bias3=5 x=01", 8'h01, 8'h08);

        // bias write in the same cycle as accept is used by that vector
        @(negedge clk);
        cfg_neuron = 3'd3;
        cfg_index  = 4'd8;
        cfg_data   = 8'd0;
        cfg_valid  = 1'b1;
        in_x       = 8'h00;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        wait_done(lat);
        check("same-cycle cfg latency", lat, 9);
        check("same-cycle cfg out_y", out_y, 8'h00);
        handshake();

        // out-of-range index writes are discarded
        cfg_write(3'd0, 4'd12, 8'd200);
        cfg_write(3'd0, 4'd9, 8'd200);
        run_vec("idx 12 discarded", 8'h10, 8'h00);
        run_vec("idx 9 discarded", 8'h02, 8'h00);
`endif

        // hold in DONE with a cfg write attempted
        accept(8'h03);
        wait_done(lat);
        check("hold latency", lat, 9);
        @(negedge clk);
        cfg_neuron = 3'd0;
        cfg_index  = 4'd8;
        cfg_data   = 8'd200;
        cfg_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold %0d out_valid", c), out_valid, 1);
            check($sformatf("hold %0d out_y", c), out_y, 8'hFF);
            check($sformatf("hold %0d in_ready", c), in_ready, 0);
            check($sformatf("hold %0d cfg_ready", c), cfg_ready, 0);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        handshake();
        run_vec("cfg in DONE dropped", 8'h01, 8'h00);

`ifdef WEIGHT_LOAD_EN
        // all weights and biases at max: 9 * 255 = 2295 without wrap
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 9; k++) begin
                cfg_write(3'(n), 4'(k), 8'd255);
            end
        end
        accept(8'hFF);
        wait_done(lat);
        check("max latency", lat, 9);
        check("max out_y", out_y, 8'hFF);
        check("max acc neuron 7", dut.g_neuron[7].u_mac.r_acc, 2295);
        handshake();
`else
        // cfg port ignored without runtime loading
        @(negedge clk);
        cfg_neuron = 3'd0;
        cfg_index  = 4'd8;
        cfg_data   = 8'd200;
        cfg_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("fixed cfg_ready %0d", c), cfg_ready, 0);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        run_vec("fixed weights x=01", 8'h01, 8'h00);
`endif

        // reset in COMPUTE cycle 4 aborts the vector and restores defaults
        accept(8'h03);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort out_y", out_y, 0);
        check("abort in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort in_ready next", in_ready, 1);
        check("abort out_valid next", out_valid, 0);
        run_vec("after abort x=01", 8'h01, 8'h00);
        run_vec("after abort x=03", 8'h03, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
